// File: rtl/spi_slave_if.sv
// On-chip side of the SPI responder: transmit handshake, receive strobe and status.
// Latency: none; this is wiring only.
// Backpressure: tx_valid/tx_ready. The receive side has no backpressure (rx_valid is a one-cycle strobe).
//
// Ports (slave view):
//   tx_data/tx_valid  in   word offered for the next frame
//   tx_ready          out  one-entry transmit buffer is empty
//   rx_data/rx_valid  out  last complete received word, one-cycle update strobe
//   tx_underrun       out  one-cycle strobe: a word was loaded from an empty buffer
//   busy              out  synchronised chip select is low
interface spi_slave_if #(
    parameter int word_width = 8
);
    logic [word_width-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [word_width-1:0] rx_data;
    logic                  rx_valid;
    logic                  tx_underrun;
    logic                  busy;

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, rx_data, rx_valid, tx_underrun, busy
    );

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, rx_data, rx_valid, tx_underrun, busy
    );
endinterface

// File: rtl/spi_slave.sv
// SPI mode-0 responder, MSB first: deserialises MOSI into words and serialises a one-entry tx buffer onto MISO.
// Latency: pin-to-strobe takes 3 clk (2 synchroniser flops + edge detect); MISO is valid <= 4 clk after an SCLK/SS fall.
// Backpressure: tx_ready low while the buffer holds a word. The master is never stalled; an empty buffer sends zeros and flags tx_underrun.
//
// Ports:
//   clk, rst_n         system clock (>= 8x SCLK), asynchronous active-low reset
//   SCLK, SS, MOSI     asynchronous SPI pins from the master
//   MISO, MISO_OE      slave data out; enable is high while the synchronised SS is low
//   bus (slave)        tx handshake, rx word/strobe, underrun strobe, busy
module spi_slave #(
    parameter int word_width = 8    // bits per SPI word, minimum 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          SCLK,
    input  logic          SS,
    input  logic          MOSI,
    output logic          MISO,
    output logic          MISO_OE,
    spi_slave_if.slave    bus
);

    localparam int CW = $clog2(word_width + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(word_width - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(word_width);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    state_t state, state_nxt;

    // ------------------------------------------------------------------
    // Pin synchronisers. The *_prev flops give edge detection on the
    // synchronised value. Reset values match an idle bus (SCLK low, SS high)
    // so leaving reset never creates a false edge.
    // ------------------------------------------------------------------
    logic sclk_meta, sclk_sync, sclk_prev;
    logic ss_meta, ss_sync, ss_prev;
    logic mosi_meta, mosi_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_meta <= 1'b0;
            sclk_sync <= 1'b0;
            sclk_prev <= 1'b0;
            ss_meta   <= 1'b1;
            ss_sync   <= 1'b1;
            ss_prev   <= 1'b1;
            mosi_meta <= 1'b0;
            mosi_sync <= 1'b0;
        end else begin
            sclk_meta <= SCLK;
            sclk_sync <= sclk_meta;
            sclk_prev <= sclk_sync;
            ss_meta   <= SS;
            ss_sync   <= ss_meta;
            ss_prev   <= ss_sync;
            mosi_meta <= MOSI;
            mosi_sync <= mosi_meta;
        end
    end

    logic sclk_rise, sclk_fall, ss_fall, ss_rise;

    assign sclk_rise = sclk_sync & ~sclk_prev;
    assign sclk_fall = ~sclk_sync & sclk_prev;
    assign ss_fall   = ~ss_sync & ss_prev;
    assign ss_rise   = ss_sync & ~ss_prev;

    // ------------------------------------------------------------------
    // Datapath state
    // ------------------------------------------------------------------
    logic [word_width-1:0] tx_buf;
    logic                  tx_full;
    logic [word_width-1:0] tx_shift;
    // Only the low word_width-1 received bits need holding. The newest bit
    // completes the word directly into rx_data.
    logic [word_width-2:0] rx_shift;
    logic [word_width-1:0] rx_next;
    logic [CW-1:0]         bit_cnt;
    logic [word_width-1:0] rx_data_q;
    logic                  rx_valid_q;
    logic                  tx_underrun_q;
    logic                  miso_q;

    logic tx_accept;
    logic do_load, do_rise, do_shift, word_last;

    assign tx_accept = bus.tx_valid & ~tx_full;
    assign rx_next   = {rx_shift, mosi_sync};
    assign word_last = do_rise & (bit_cnt == CNT_LAST);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        do_load   = 1'b0;
        do_rise   = 1'b0;
        do_shift  = 1'b0;
        // A chip-select release aborts from any state. It also beats an
        // SCLK edge that is seen in the same cycle.
        if (ss_rise) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ss_fall) begin
                        state_nxt = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    do_load   = 1'b1;
                    state_nxt = ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (sclk_rise && (bit_cnt != CNT_FULL)) begin
                        do_rise = 1'b1;
                    end else if (sclk_fall) begin
                        // A fall after a complete word starts the next
                        // word while SS stays low.
                        if (bit_cnt == CNT_FULL) begin
                            state_nxt = ST_LOAD;
                        end else begin
                            do_shift = 1'b1;
                        end
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Buffer, shifters, counters and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_buf        <= '0;
            tx_full       <= 1'b0;
            tx_shift      <= '0;
            rx_shift      <= '0;
            bit_cnt       <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            tx_underrun_q <= 1'b0;
            miso_q        <= 1'b0;
        end else begin
            rx_valid_q    <= 1'b0;
            tx_underrun_q <= 1'b0;

            // A LOAD with an empty buffer sees the pre-accept state. A word
            // accepted in that same cycle is kept for the next load.
            if (tx_accept) begin
                tx_buf  <= bus.tx_data;
                tx_full <= 1'b1;
            end else if (do_load) begin
                tx_full <= 1'b0;
            end

            if (state_nxt == ST_IDLE) begin
                miso_q <= 1'b0;
            end

            if (ss_rise) begin
                bit_cnt <= '0;
            end

            if (do_load) begin
                bit_cnt <= '0;
                if (tx_full) begin
                    tx_shift <= tx_buf;
                    miso_q   <= tx_buf[word_width-1];
                end else begin
                    tx_shift      <= '0;
                    miso_q        <= 1'b0;
                    tx_underrun_q <= 1'b1;
                end
            end

            if (do_rise) begin
                rx_shift <= rx_next[word_width-2:0];
                bit_cnt  <= bit_cnt + 1'b1;
                if (word_last) begin
                    rx_data_q  <= rx_next;
                    rx_valid_q <= 1'b1;
                end
            end

            if (do_shift) begin
                tx_shift <= tx_shift << 1;
                miso_q   <= tx_shift[word_width-2];
            end
        end
    end

    assign MISO            = miso_q;
    assign MISO_OE         = ~ss_sync;
    assign bus.busy        = ~ss_sync;
    assign bus.tx_ready    = ~tx_full;
    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.tx_underrun = tx_underrun_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave (word_width = 8): an SPI mode-0 master model drives the pins at 1/10 clk rate.
// Latency: expected values are hand-computed. Received words and strobes are logged 1 ns after each clk rise.
// Backpressure: tx words are pushed through the valid/ready handshake with a bounded wait.
module tb_spi_slave;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic SCLK = 1'b0;
    logic SS = 1'b1;
    logic MOSI = 1'b0;
    logic MISO;
    logic MISO_OE;

    spi_slave_if #(.word_width(8)) bus ();

    spi_slave #(.word_width(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .SCLK    (SCLK),
        .SS      (SS),
        .MOSI    (MOSI),
        .MISO    (MISO),
        .MISO_OE (MISO_OE),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int rx_cnt = 0;
    int ur_cnt = 0;
    logic [7:0] rx_log [$];

    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            if (bus.rx_valid) begin
                rx_cnt++;
                rx_log.push_back(bus.rx_data);
            end
            if (bus.tx_underrun) ur_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_tx(input logic [7:0] d);
        int n = 0;
        @(negedge clk);
        while (!bus.tx_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!bus.tx_ready) chk("push_timeout", 32'(bus.tx_ready), 1);
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
    endtask

    // Each bit: SCLK low (master shifts), half period, sample MISO, SCLK high.
    // Ends with SCLK high so the frame can be closed by raising SS first.
    task automatic spi_bits(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        mi = '0;
        for (int i = 0; i < nbits; i++) begin
            SCLK = 1'b0;
            MOSI = mo[7-i];
            #50;
            mi = {mi[6:0], MISO};
            SCLK = 1'b1;
            #50;
        end
    endtask

    task automatic ss_low();
        SS = 1'b0;
        #60;
    endtask

    task automatic end_frame();
        SS = 1'b1;
        #40;
        SCLK = 1'b0;
        #60;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] mi;
        logic [7:0] mi2;
        int r0, u0;

        bus.tx_data  = '0;
        bus.tx_valid = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_miso", 32'(MISO), 0);
        chk("rst_miso_oe", 32'(MISO_OE), 0);
        chk("rst_tx_ready", 32'(bus.tx_ready), 1);
        chk("rst_rx_valid", 32'(bus.rx_valid), 0);
        chk("rst_rx_data", 32'(bus.rx_data), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Single word: tx 0xA5, master sends 0x3C
        push_tx(8'hA5);
        chk("single_tx_ready_full", 32'(bus.tx_ready), 0);
        r0 = rx_cnt; u0 = ur_cnt;
        ss_low();
        chk("single_busy", 32'(bus.busy), 1);
        chk("single_miso_oe", 32'(MISO_OE), 1);
        chk("single_tx_ready_after_load", 32'(bus.tx_ready), 1);
        spi_bits(8'h3C, 8, mi);
        chk("single_miso_word", 32'(mi), 32'hA5);
        end_frame();
        chk("single_rx_count", 32'(rx_cnt - r0), 1);
        chk("single_rx_data", 32'(bus.rx_data), 32'h3C);
        chk("single_rx_log", 32'(rx_log[$]), 32'h3C);
        chk("single_underrun", 32'(ur_cnt - u0), 0);
        chk("single_oe_off", 32'(MISO_OE), 0);

        // Back-to-back: 0x81 preloaded, 0x7E pushed during the first word
        push_tx(8'h81);
        r0 = rx_cnt; u0 = ur_cnt;
        fork
            begin
                ss_low();
                spi_bits(8'h12, 8, mi);
                spi_bits(8'h34, 8, mi2);
            end
            push_tx(8'h7E);
        join
        chk("b2b_miso_w0", 32'(mi), 32'h81);
        chk("b2b_miso_w1", 32'(mi2), 32'h7E);
        end_frame();
        chk("b2b_rx_count", 32'(rx_cnt - r0), 2);
        chk("b2b_rx_w0", 32'(rx_log[rx_log.size()-2]), 32'h12);
        chk("b2b_rx_w1", 32'(rx_log[rx_log.size()-1]), 32'h34);
        chk("b2b_underrun", 32'(ur_cnt - u0), 0);

        // Underrun: empty buffer, master sends 0xFF
        r0 = rx_cnt; u0 = ur_cnt;
        ss_low();
        spi_bits(8'hFF, 8, mi);
        end_frame();
        chk("urun_pulses", 32'(ur_cnt - u0), 1);
        chk("urun_miso", 32'(mi), 0);
        chk("urun_rx_data", 32'(bus.rx_data), 32'hFF);
        chk("urun_rx_count", 32'(rx_cnt - r0), 1);

        // Abort after 5 rises, then a full 0x55 frame
        r0 = rx_cnt;
        ss_low();
        spi_bits(8'h0F, 5, mi);
        end_frame();
        chk("abort_rx_count", 32'(rx_cnt - r0), 0);
        chk("abort_rx_data_kept", 32'(bus.rx_data), 32'hFF);
        ss_low();
        spi_bits(8'h55, 8, mi);
        end_frame();
        chk("after_abort_rx_data", 32'(bus.rx_data), 32'h55);
        chk("after_abort_rx_count", 32'(rx_cnt - r0), 1);

        // SS rise coincident with the final SCLK rise: the abort wins
        r0 = rx_cnt;
        ss_low();
        spi_bits(8'hAA, 7, mi);
        SCLK = 1'b0;
        MOSI = 1'b0;
        #50;
        SCLK = 1'b1;
        SS   = 1'b1;
        #40;
        SCLK = 1'b0;
        #60;
        chk("coinc_rx_count", 32'(rx_cnt - r0), 0);
        chk("coinc_rx_data", 32'(bus.rx_data), 32'h55);

        // tx_valid in exactly the LOAD cycle with an empty buffer
        u0 = ur_cnt;
        @(negedge clk);
        SS = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus.tx_data  = 8'hC3;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        chk("simacc_tx_ready", 32'(bus.tx_ready), 0);
        #40;
        chk("simacc_underrun", 32'(ur_cnt - u0), 1);
        spi_bits(8'h00, 8, mi);
        end_frame();
        chk("simacc_miso_f1", 32'(mi), 0);
        u0 = ur_cnt;
        ss_low();
        spi_bits(8'h99, 8, mi);
        end_frame();
        chk("simacc_miso_f2", 32'(mi), 32'hC3);
        chk("simacc_f2_underrun", 32'(ur_cnt - u0), 0);
        chk("simacc_f2_rx", 32'(bus.rx_data), 32'h99);

        // Reset during bit 3, with a word waiting in the buffer
        push_tx(8'hFF);
        ss_low();
        push_tx(8'h11);
        spi_bits(8'h00, 3, mi);
        chk("rstmid_pre_miso", 32'(MISO), 1);
        chk("rstmid_pre_tx_ready", 32'(bus.tx_ready), 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid_miso", 32'(MISO), 0);
        chk("rstmid_miso_oe", 32'(MISO_OE), 0);
        chk("rstmid_tx_ready", 32'(bus.tx_ready), 1);
        chk("rstmid_rx_valid", 32'(bus.rx_valid), 0);
        chk("rstmid_busy", 32'(bus.busy), 0);
        chk("rstmid_rx_data", 32'(bus.rx_data), 0);
        #7;
        SS = 1'b1;
        SCLK = 1'b0;
        #20;
        rst_n = 1'b1;
        #50;
        chk("rstmid_idle_oe", 32'(MISO_OE), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI responder (slave), the peripheral side of the SPI master interface: mode 0 (CPOL=0, CPHA=0), MSB first, one chip-select.
- Oversamples the external SCLK/SS/MOSI in the system clk domain.
- Deserialises MOSI into receive words and serialises a one-entry transmit buffer onto MISO.
- Sits between the external SPI pins and on-chip logic, with a valid/ready transmit handshake and a single-cycle receive strobe.

Parameters:
word_width, 8, bits per SPI word; minimum 2.

Ports:
clk  in  1  system clock; all state on rising edge; must be ≥ 8× SCLK frequency.
rst_n  in  1  asynchronous, active-low reset.
SCLK  in  1  SPI serial clock from master, asynchronous to clk.
SS  in  1  chip select, active low, asynchronous.
MOSI  in  1  master-out data, asynchronous.
MISO  out  1  slave-out data.
MISO_OE  out  1  MISO output enable; 1 only while the synchronised SS is low.
tx_data  in  word_width  word to transmit.
tx_valid  in  1  tx_data offered.
tx_ready  out  1  transmit buffer empty.
rx_data  out  word_width  last complete received word; held until the next complete word.
rx_valid  out  1  one-cycle strobe: rx_data updated.
tx_underrun  out  1  one-cycle strobe: a word was loaded while the tx buffer was empty.
busy  out  1  synchronised SS low.

Behaviour:
- Reset (rst_n=0, asynchronous): all outputs 0 except tx_ready=1; shift registers, bit counter and tx buffer are cleared; synchroniser flops are set to SCLK=0, SS=1, MOSI=0; FSM goes to IDLE.
- Synchronisation: SCLK, SS and MOSI each pass through 2 flops. Edge strobes sclk_rise and sclk_fall come from the synchronised SCLK versus its previous value, as are ss_fall and ss_rise. Latency from pin to strobe is 3 clk.
- tx buffer: one entry. A word is accepted on tx_valid & tx_ready; tx_ready falls the next cycle. The buffer is consumed at each word load (LOAD), and tx_ready rises the cycle after the load.
- FSM:
  - IDLE: MISO_OE=0, MISO=0. On ss_fall go to LOAD.
  - LOAD (1 cycle): tx_shift ← buffer if full, else all-zeros and tx_underrun=1. MISO ← tx_shift[MSB]. bit_cnt ← 0. Go to SHIFT.
  - SHIFT:
    - On sclk_rise: rx_shift ← {rx_shift[word_width-2:0], MOSI_sync}; bit_cnt++.
    - If bit_cnt reaches word_width on that rise: rx_data ← new rx_shift and rx_valid=1 the next cycle. The next sclk_fall goes to LOAD (back-to-back word, SS still low).
    - Otherwise on sclk_fall: tx_shift shifts left and MISO ← next bit.
  - Any state, on ss_rise: go to IDLE in the same cycle. A partial word is discarded (no rx_valid, rx_data unchanged) and bit_cnt is cleared. A word already loaded from the buffer is lost, and the buffer is not restored.
- Simultaneous events:
  - tx accept in the same cycle as LOAD: LOAD sees the pre-accept buffer state. If it was empty, underrun fires and the accepted word stays for the next load.
  - ss_rise together with the final sclk_rise: the abort wins and no rx_valid is generated.
  - ss_fall while not in IDLE cannot occur; SS glitches shorter than 3 clk are filtered by the synchroniser only as far as sampling allows.
- Width rules: bit_cnt is $clog2(word_width+1) bits. rx_data and tx_data are word_width bits with no sign handling.
- Timing: MISO is valid ≤ 4 clk after an SCLK falling edge or SS falling edge. The master must leave ≥ 4 clk between SS fall and the first SCLK rise.

Test Plan:
- Reset mid-transfer: assert rst_n=0 during bit 3 -> MISO=0, MISO_OE=0, tx_ready=1, rx_valid=0, and the FSM returns to IDLE immediately without a clk edge.
- Single word, word_width=8: preload tx 0xA5, master sends 0x3C -> MISO bits 1,0,1,0,0,1,0,1; rx_data=0x3C with one rx_valid pulse; tx_ready back to 1 after LOAD.
- Back-to-back: tx 0x81 then 0x7E accepted during the first word, master sends 0x12, 0x34 with SS held low -> rx_valid twice with 0x12 then 0x34; MISO carries 0x81 then 0x7E; no underrun.
- Underrun: buffer empty at ss_fall, master sends 0xFF -> tx_underrun pulses once, MISO all 0, rx_data=0xFF.
- Abort: SS raised after 5 SCLK rises -> no rx_valid, rx_data keeps its previous value; the next full frame sending 0x55 gives rx_data=0x55.
- Simultaneous accept/LOAD: tx_valid asserted in the LOAD cycle with the buffer empty -> underrun=1, and the word is transmitted in the following frame.
